// File: rtl/simple_err_mem.sv
// Simple DEPTH x 32 memory with independent write/read request ports, a fixed
// two-cycle read pipeline with write-first bypass, occupancy count and sticky errors.
package simple_err_mem_pkg;
  typedef struct packed {
    logic       wr_vld;
    logic [5:0] wr_address;
    logic       rd_vld;
    logic [5:0] rd_address;
  } expected_int_32_6;
endpackage

module simple_err_mem
  import simple_err_mem_pkg::*;
#(
  parameter int DEPTH = 36,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  expected_int_32_6 expected_int,
  input  logic [31:0]      expected_int_wr_data,
  input  logic             clr_err,
  output logic [31:0]      expected_int_rd_data,
  output logic             rd_data_vld,
  output logic [6:0]       count,
  output logic             ovf,
  output logic             udf,
  output logic             addr_err
);

  // Handshake: wr_vld/rd_vld are one-cycle qualifiers with no backpressure; a request
  // is accepted in the cycle it is valid and in range, and rd_data_vld pulses two
  // cycles after an accepted read.
  localparam logic [AW:0] DEPTH_A = (AW + 1)'(DEPTH);
  localparam logic [6:0]  DEPTH_C = 7'(DEPTH);

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] wr_a, rd_a;
  logic          wr_in, rd_in, wr_acc, rd_acc, wr_bad, rd_bad;
  logic [31:0]   rd_word;
  logic          s1_vld;
  logic [31:0]   s1_data;
  logic [6:0]    count_nxt;
  logic          ovf_set, udf_set, aerr_set;

  assign wr_a   = AW'(expected_int.wr_address);
  assign rd_a   = AW'(expected_int.rd_address);
  assign wr_in  = {1'b0, wr_a} < DEPTH_A;
  assign rd_in  = {1'b0, rd_a} < DEPTH_A;
  assign wr_acc = expected_int.wr_vld && wr_in && !reset;
  assign rd_acc = expected_int.rd_vld && rd_in && !reset;
  assign wr_bad = expected_int.wr_vld && !wr_in && !reset;
  assign rd_bad = expected_int.rd_vld && !rd_in && !reset;

  // Same-cycle write to the read address wins, so the read sees end-of-cycle content.
  assign rd_word = (wr_acc && (wr_a == rd_a)) ? expected_int_wr_data : mem[rd_a];

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_a] <= expected_int_wr_data;
  end

  always_comb begin
    count_nxt = count;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    aerr_set  = wr_bad || rd_bad;
    if (wr_acc && !rd_acc) begin
      if (count == DEPTH_C) ovf_set = 1'b1;
      else count_nxt = count + 7'd1;
    end else if (rd_acc && !wr_acc) begin
      if (count == 7'd0) udf_set = 1'b1;
      else count_nxt = count - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld               <= 1'b0;
      s1_data              <= '0;
      rd_data_vld          <= 1'b0;
      expected_int_rd_data <= '0;
      count                <= '0;
      ovf                  <= 1'b0;
      udf                  <= 1'b0;
      addr_err             <= 1'b0;
    end else begin
      s1_vld      <= rd_acc;
      if (rd_acc) s1_data <= rd_word;
      rd_data_vld <= s1_vld;
      if (s1_vld) expected_int_rd_data <= s1_data;
      count       <= count_nxt;
      ovf         <= ovf_set  || (ovf      && !clr_err);
      udf         <= udf_set  || (udf      && !clr_err);
      addr_err    <= aerr_set || (addr_err && !clr_err);
    end
  end

endmodule

// File: tb/tb_simple_err_mem.sv
// Bench for simple_err_mem: directed request cycles, a bench-side memory model feeding
// an expected-read queue, and a negedge monitor that checks every output cycle.
module tb_simple_err_mem;
  import simple_err_mem_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  expected_int_32_6 req = '0;
  logic [31:0]      wr_data = '0;
  logic             clr_err = 1'b0;
  logic [31:0]      rd_data;
  logic             rd_data_vld;
  logic [6:0]       count;
  logic             ovf, udf, addr_err;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;
  bit prev_rst = 1'b0;
  logic [31:0] last_data = '0;
  logic [31:0] exp_q[$];
  logic [31:0] model [64];

  simple_err_mem #(.DEPTH(36), .AW(6)) dut (
    .clk(clk), .reset(reset), .expected_int(req), .expected_int_wr_data(wr_data),
    .clr_err(clr_err), .expected_int_rd_data(rd_data), .rd_data_vld(rd_data_vld),
    .count(count), .ovf(ovf), .udf(udf), .addr_err(addr_err)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // driver: one call = one clock cycle of request inputs
  task automatic step(input bit wv, input int wa, input logic [31:0] wd, input bit rv,
                      input int ra, input bit clr, input bit rst, input bit flush);
    @(posedge clk);
    #1;
    req.wr_vld     = wv;
    req.wr_address = 6'(wa);
    req.rd_vld     = rv;
    req.rd_address = 6'(ra);
    wr_data        = wd;
    clr_err        = clr;
    reset          = rst;
    if (flush) exp_q.delete();
    if (!rst) begin
      if (wv && wa < 36) model[wa] = wd;
      if (rv && ra < 36) exp_q.push_back(model[ra]);
    end
  endtask

  task automatic idle();                           step(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input int a, input logic [31:0] d); step(1, a, d, 0, 0, 0, 0, 0); endtask
  task automatic rd(input int a);                  step(0, 0, 0, 1, a, 0, 0, 0); endtask
  task automatic clr();                            step(0, 0, 0, 0, 0, 1, 0, 0); endtask
  task automatic sample();                         @(negedge clk); endtask
  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle();
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (started) begin
      if (rd_data_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rd_vld", 32'd1, 32'd0);
        end else begin
          chk("rd_data", rd_data, exp_q.pop_front());
        end
        last_data = rd_data;
      end else begin
        if (prev_rst) last_data = '0;
        chk("rd_hold", rd_data, last_data);
      end
    end
    prev_rst = reset;
  end

  initial begin
    idle_init();
    // reset state
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    sample();
    chk("rst_data", rd_data, 32'd0);
    chk("rst_vld", {31'd0, rd_data_vld}, 32'd0);
    chk("rst_count", {25'd0, count}, 32'd0);
    chk("rst_flags", {29'd0, ovf, udf, addr_err}, 32'd0);
    started = 1'b1;

    // write 5 in cycle 0, read 5 in cycle 3
    wr(5, 32'h3F80_0000);
    idle();
    sample(); chk("t1_count1", {25'd0, count}, 32'd1);
    idle();
    rd(5);
    idle();
    sample(); chk("t1_count0", {25'd0, count}, 32'd0);
    idle();

    // write-first bypass and in-flight protection
    wr(7, 32'h1111_1111);
    step(1, 7, 32'h4000_0000, 1, 7, 0, 0, 0);
    wr(7, 32'h2222_2222);
    idle();
    sample(); chk("t2_count", {25'd0, count}, 32'd2);
    rd(7);
    idle();
    sample(); chk("t2_count_rd", {25'd0, count}, 32'd1);
    idle();
    idle();
    do_reset();

    // fill, then overflow write
    for (int a = 0; a < 36; a++) wr(a, 32'hA500_0000 | 32'(a));
    idle();
    sample(); chk("t3_full", {25'd0, count}, 32'd36);
    chk("t3_no_ovf", {31'd0, ovf}, 32'd0);
    wr(0, 32'hDEAD_BEEF);
    idle();
    sample(); chk("t3_sat", {25'd0, count}, 32'd36);
    chk("t3_ovf", {31'd0, ovf}, 32'd1);
    rd(0);
    idle();
    sample(); chk("t3_count_rd", {25'd0, count}, 32'd35);
    idle();
    idle();
    do_reset();

    // underflow and clear; contents survive reset
    sample(); chk("t4_ovf_rst", {31'd0, ovf}, 32'd0);
    rd(3);
    idle();
    sample(); chk("t4_udf", {31'd0, udf}, 32'd1);
    chk("t4_count", {25'd0, count}, 32'd0);
    clr();
    idle();
    sample(); chk("t4_udf_clr", {31'd0, udf}, 32'd0);
    step(0, 0, 0, 1, 3, 1, 0, 0);
    idle();
    sample(); chk("t4_set_wins", {31'd0, udf}, 32'd1);
    chk("t4_count2", {25'd0, count}, 32'd0);

    // address errors and independent ports
    clr();
    wr(1, 32'h1234_5678);
    idle();
    sample(); chk("t5_count", {25'd0, count}, 32'd1);
    chk("t5_udf0", {31'd0, udf}, 32'd0);
    step(1, 40, 32'hFFFF_FFFF, 1, 36, 0, 0, 0);
    idle();
    sample(); chk("t5_aerr", {31'd0, addr_err}, 32'd1);
    chk("t5_count_hold", {25'd0, count}, 32'd1);
    step(1, 2, 32'h0BAD_F00D, 1, 1, 0, 0, 0);
    idle();
    sample(); chk("t5_both", {25'd0, count}, 32'd1);
    chk("t5_aerr_sticky", {31'd0, addr_err}, 32'd1);
    clr();
    idle();
    sample(); chk("t5_aerr_clr", {31'd0, addr_err}, 32'd0);
    rd(2);
    idle();
    idle();

    // streamed reads with reset in cycle 10
    for (int i = 0; i < 36; i++) begin
      step(0, 0, 0, 1, i % 36, 0, (i == 10), (i == 11));
      if (i == 11 || i == 12) begin
        sample();
        chk("t6_vld_off", {31'd0, rd_data_vld}, 32'd0);
        chk("t6_count", {25'd0, count}, 32'd0);
      end
    end
    idle();
    idle();
    idle();
    sample();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic idle_init();
    for (int i = 0; i < 64; i++) model[i] = '0;
  endtask

endmodule

// File: doc/simple_err_mem.md
SIMPLE_ERR_MEM -- requirements
Module: simple_err_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 36, number of 32-bit words stored.
REQ-002 SHALL have parameter AW, default 6, address width of both ports.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port expected_int  input  expected_int_32_6  request struct: wr_vld, wr_address[5:0], rd_vld, rd_address[5:0].
REQ-007 SHALL have port expected_int_wr_data  input  32  write data, paired with expected_int.wr_vld.
REQ-008 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-009 SHALL have port expected_int_rd_data  output  32  registered read data.
REQ-010 SHALL have port rd_data_vld  output  1  expected_int_rd_data carries the result of a read.
REQ-011 SHALL have port count  output  7  occupancy, 0..DEPTH.
REQ-012 SHALL have port ovf  output  1  sticky: write accepted while count==DEPTH.
REQ-013 SHALL have port udf  output  1  sticky: read accepted while count==0.
REQ-014 SHALL have port addr_err  output  1  sticky: request with address >= DEPTH on either port.

Function
REQ-015 SHALL hold a DEPTH x 32 array; array contents are not reset, and reads of never-written words return undefined data.
REQ-016 SHALL accept a write when wr_vld=1 and wr_address<DEPTH, and store wr_data to that word at the clock edge.
REQ-017 SHALL accept a read when rd_vld=1 and rd_address<DEPTH.
REQ-018 SHALL deliver a read accepted in cycle T with rd_data_vld=1 and the data in cycle T+2; latency is fixed, with a two-stage pipeline and full throughput of one read per cycle.
REQ-019 SHALL return for a read the word value as of the end of cycle T, including a same-cycle write to the same address (write-first bypass).
REQ-020 SHALL NOT let writes in cycles T+1 or T+2 alter data already in flight for a read accepted in T.
REQ-021 SHALL hold expected_int_rd_data at its last value when rd_data_vld=0.
REQ-022 SHALL increment count on an accepted write only, decrement it on an accepted read only, and leave it unchanged when both are accepted in the same cycle.
REQ-023 SHALL saturate count at DEPTH on a write-only cycle with count==DEPTH, set ovf, and still perform the write.
REQ-024 SHALL hold count at 0 on a read-only cycle with count==0, set udf, and still perform the read.
REQ-025 SHALL ignore a request with address >= DEPTH (no write, no rd_data_vld, no count change) and set addr_err.
REQ-026 SHALL clear ovf, udf and addr_err on clr_err=1, except that a flag whose set condition is true in the same cycle is set (set wins).
REQ-027 SHALL evaluate wr and rd on independent ports, so simultaneous write and read to different addresses both complete.

Reset
REQ-028 SHALL, while reset=1, drive expected_int_rd_data=0, rd_data_vld=0, count=0, ovf=0, udf=0 and addr_err=0 in the following cycle.
REQ-029 SHALL discard all in-flight reads on reset, with no rd_data_vld after reset deasserts for reads accepted before or during reset.
REQ-030 SHALL ignore requests while reset=1, while leaving array contents written before reset unchanged.

Verification
REQ-031 SHALL verify: write 0x3F800000 at address 5 in cycle 0, read address 5 in cycle 3 -> cycle 5 rd_data_vld=1 with data 0x3F800000, and count is 1 then 0.
REQ-032 SHALL verify: write 0x40000000 and read address 7 in the same cycle T, after an earlier write of 0x11111111 to address 7 -> T+2 data 0x40000000; a write of 0x22222222 to address 7 at T+1 does not change it.
REQ-033 SHALL verify: 36 writes to addresses 0..35, then one write to address 0 -> count stays 36, ovf=1, and a later read of address 0 returns the new data.
REQ-034 SHALL verify: read with count==0 -> udf=1 and count=0; clr_err pulse -> udf=0 next cycle; clr_err together with a new underflow -> udf stays 1.
REQ-035 SHALL verify: write to address 40 and read of address 36 -> addr_err=1, count unchanged, no rd_data_vld.
REQ-036 SHALL verify: reads streamed every cycle for 36 cycles with reset asserted in cycle 10 -> rd_data_vld=0 from cycle 11 onward until new reads are issued after reset deasserts, and count=0.
